// File: rtl/tiny_dnn_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : tiny_dnn_axil_master
// Brief    : Single-outstanding AXI4-Lite master. It turns one command into
//            one AXI write or read and returns a single response with an
//            error flag. A per-state wait counter aborts stuck transfers.
// Revision : 1.0  initial release
// ============================================================================
module tiny_dnn_axil_master #(
  parameter int TIMEOUT = 255,
  parameter int DW      = 16
) (
  input  logic          M_AXI_ACLK,
  input  logic          M_AXI_ARESET,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [31:0]   cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  // AXI write address / data / response
  output logic [31:0]   M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  // AXI read address / data
  output logic [31:0]   M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  localparam logic [31:0] c_TMO = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_arvalid;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [31:0]   r_cnt;
  logic          w_chan;
  logic          w_timeout;
  logic          w_accept;
  logic          w_unused;

  // Upper read-data bits beyond DW are intentionally discarded.
  assign w_unused = ^M_AXI_RDATA;

  assign w_chan    = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                     (r_state == S_RADDR) || (r_state == S_RDATA);
  assign w_timeout = w_chan && (c_TMO != 32'd0) && (r_cnt == c_TMO - 32'd1);
  assign w_accept  = cmd_valid && (r_state == S_IDLE);

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'b1111;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_ARVALID = r_arvalid;
  assign rsp_write     = r_write;
  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_state_nx;
  end

  // Next-state decode and state-derived handshake outputs; timeout overrides.
  always_comb begin
    w_state_nx   = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nx = cmd_write ? S_WADDR : S_RADDR;
      end
      S_WADDR: begin
        // A channel is finished once its VALID has dropped or handshakes now.
        if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY))
          w_state_nx = S_WRESP;
      end
      S_WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) w_state_nx = S_RESP;
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) w_state_nx = S_RDATA;
      end
      S_RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) w_state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nx   = S_RESP;
      M_AXI_BREADY = 1'b0;
      M_AXI_RREADY = 1'b0;
    end
  end

  // Command capture, VALID tracking, response capture and wait counter.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= 32'(cmd_wdata);
        r_write <= cmd_write;
        r_rdata <= '0;
        r_err   <= 1'b0;
        if (cmd_write) begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end else begin
          r_arvalid <= 1'b1;
        end
      end
      if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
      if (r_wvalid  && M_AXI_WREADY)  r_wvalid  <= 1'b0;
      if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
      if (r_state == S_WRESP && M_AXI_BVALID)
        r_err <= (M_AXI_BRESP != 2'b00);
      if (r_state == S_RDATA && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA[DW-1:0];
        r_err   <= (M_AXI_RRESP != 2'b00);
      end
      if (w_timeout) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rdata   <= '0;
        r_err     <= 1'b1;
      end
      // Counter restarts on every state entry.
      if (w_state_nx != r_state) r_cnt <= '0;
      else if (w_chan)           r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_dnn_axil_master
// Brief    : Directed bench for tiny_dnn_axil_master (TIMEOUT = 8, DW = 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_tiny_dnn_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [15:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tiny_dnn_axil_master #(.TIMEOUT(8), .DW(16)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    tick(); tick();
    // reset state
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_wvalid",  {31'd0, wvalid}, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_bready",  {31'd0, bready}, 0);
    chk("rst_rready",  {31'd0, rready}, 0);
    chk("rst_rspv",    {31'd0, rsp_valid}, 0);
    chk("rst_err",     {31'd0, rsp_err}, 0);
    chk("rst_rdata",   {16'd0, rsp_rdata}, 0);
    chk("rst_awaddr",  awaddr, 0);
    chk("rst_wdata",   wdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmdrdy", {31'd0, cmd_ready}, 1);

    // zero-wait write 0x0008 <- 0x1234
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    issue(1'b1, 32'h8, 16'h1234);
    chk("w1_awvalid", {31'd0, awvalid}, 1);
    chk("w1_wvalid",  {31'd0, wvalid}, 1);
    chk("w1_awaddr",  awaddr, 32'h8);
    chk("w1_wdata",   wdata, 32'h0000_1234);
    chk("w1_wstrb",   {28'd0, wstrb}, 32'hF);
    chk("w1_cmdrdy",  {31'd0, cmd_ready}, 0);
    tick();
    chk("w1_bready",  {31'd0, bready}, 1);
    chk("w1_awdrop",  {31'd0, awvalid}, 0);
    chk("w1_rspv_early", {31'd0, rsp_valid}, 0);
    tick();
    chk("w1_rspv",    {31'd0, rsp_valid}, 1);
    chk("w1_err",     {31'd0, rsp_err}, 0);
    chk("w1_rspw",    {31'd0, rsp_write}, 1);
    chk("w1_rdata",   {16'd0, rsp_rdata}, 0);
    awready = 0; wready = 0; bvalid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("w1_done",    {31'd0, rsp_valid}, 0);
    chk("w1_cmdrdy2", {31'd0, cmd_ready}, 1);

    // write with WREADY 4 cycles before AWREADY
    issue(1'b1, 32'h20, 16'hBEEF);
    chk("w2_awvalid", {31'd0, awvalid}, 1);
    wready = 1;
    tick();
    wready = 0;
    chk("w2_wdrop",   {31'd0, wvalid}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("w2_awhold", {31'd0, awvalid}, 1);
      chk("w2_awaddr", awaddr, 32'h20);
      chk("w2_hold_cmdrdy", {31'd0, cmd_ready}, 0);
      tick();
    end
    chk("w2_awhold4", {31'd0, awvalid}, 1);
    awready = 1;
    tick();
    awready = 0;
    chk("w2_awdrop", {31'd0, awvalid}, 0);
    chk("w2_bready", {31'd0, bready}, 1);
    bvalid = 1; bresp = 0;
    tick();
    bvalid = 0;
    chk("w2_rspv", {31'd0, rsp_valid}, 1);
    chk("w2_err",  {31'd0, rsp_err}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("w2_done", {31'd0, rsp_valid}, 0);
    tick();
    chk("w2_single", {31'd0, rsp_valid}, 0);

    // read 0x0010 returning 0xABCD5678 OKAY
    arready = 1; rvalid = 1; rdata = 32'hABCD_5678; rresp = 0;
    issue(1'b0, 32'h10, 16'h0);
    chk("r1_arvalid", {31'd0, arvalid}, 1);
    chk("r1_araddr",  araddr, 32'h10);
    chk("r1_noaw",    {31'd0, awvalid}, 0);
    tick();
    chk("r1_rready",  {31'd0, rready}, 1);
    chk("r1_ardrop",  {31'd0, arvalid}, 0);
    tick();
    chk("r1_rspv",    {31'd0, rsp_valid}, 1);
    chk("r1_rdata",   {16'd0, rsp_rdata}, 32'h5678);
    chk("r1_rspw",    {31'd0, rsp_write}, 0);
    chk("r1_err",     {31'd0, rsp_err}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read with SLVERR, response back-pressured for 5 cycles
    rdata = 32'h1111_CAFE; rresp = 2'b10;
    issue(1'b0, 32'h14, 16'h0);
    tick();
    tick();
    rvalid = 0; arready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("r2_rspv",  {31'd0, rsp_valid}, 1);
      chk("r2_err",   {31'd0, rsp_err}, 1);
      chk("r2_rdata", {16'd0, rsp_rdata}, 32'hCAFE);
      tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("r2_done", {31'd0, rsp_valid}, 0);

    // write timeout: AWREADY never asserted
    wready = 1;
    issue(1'b1, 32'h30, 16'h5555);
    chk("t_awvalid", {31'd0, awvalid}, 1);
    n = 1;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    wready = 0;
    chk("t_latency", n, 9);
    chk("t_rspv",    {31'd0, rsp_valid}, 1);
    chk("t_err",     {31'd0, rsp_err}, 1);
    chk("t_awdrop",  {31'd0, awvalid}, 0);
    chk("t_wdrop",   {31'd0, wvalid}, 0);
    chk("t_rdata",   {16'd0, rsp_rdata}, 0);
    bvalid = 1; bresp = 0;
    chk("t_bready",  {31'd0, bready}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t_bready2", {31'd0, bready}, 0);
    chk("t_awdrop2", {31'd0, awvalid}, 0);
    chk("t_idle",    {31'd0, cmd_ready}, 1);
    bvalid = 0;

    // reset asserted while in RDATA
    arready = 1; rvalid = 0;
    issue(1'b0, 32'h40, 16'h0);
    tick();
    arready = 0;
    chk("x_rready", {31'd0, rready}, 1);
    rst = 1'b1;
    tick();
    chk("x_rready0", {31'd0, rready}, 0);
    chk("x_arvalid", {31'd0, arvalid}, 0);
    chk("x_rspv",    {31'd0, rsp_valid}, 0);
    chk("x_araddr",  araddr, 0);
    rst = 1'b0;
    tick();
    chk("x_cmdrdy",  {31'd0, cmd_ready}, 1);
    chk("x_rspv2",   {31'd0, rsp_valid}, 0);
    arready = 1; rvalid = 1; rdata = 32'h0000_9ABC; rresp = 0;
    issue(1'b0, 32'h18, 16'h0);
    chk("x_araddr2", araddr, 32'h18);
    tick();
    tick();
    chk("x_rspv3",   {31'd0, rsp_valid}, 1);
    chk("x_rdata",   {16'd0, rsp_rdata}, 32'h9ABC);
    chk("x_err",     {31'd0, rsp_err}, 0);
    arready = 0; rvalid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("x_done",    {31'd0, rsp_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tiny_dnn_axil_master.md
TINY_DNN_AXIL_MASTER -- requirements
Module: tiny_dnn_axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles waited in any channel state before abort (0 = no timeout).
REQ-002 SHALL have parameter DW, default 16, meaning the command data width, zero-extended onto 32-bit AXI data.
REQ-003 SHALL have one clock and a synchronous active-high reset: M_AXI_ACLK  in  1  clock; all logic on its rising edge.
REQ-004 M_AXI_ARESET  in  1  synchronous active-high reset.
REQ-005 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 cmd_write in 1 (1 = write, 0 = read); cmd_addr in 32 (byte address); cmd_wdata in DW (write data).
REQ-007 rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-008 rsp_write out 1 (echo of cmd_write); rsp_rdata out DW (read data); rsp_err out 1 (BRESP/RRESP not OKAY, or timeout).
REQ-009 M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-010 M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-011 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-012 M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-013 M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-014 SHALL support exactly one outstanding transaction; states IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready and its addr/data/direction are registered.
REQ-016 IDLE -> WADDR on an accepted write; AWVALID and WVALID both assert in the next cycle, with AWADDR = cmd_addr, WDATA = {zeros, cmd_wdata}, WSTRB = 4'b1111.
REQ-017 In WADDR, AWVALID SHALL drop the cycle after the AWVALID&AWREADY handshake and WVALID the cycle after WVALID&WREADY, independently, in any order or simultaneously; WADDR -> WRESP once both have completed.
REQ-018 Once asserted, AWVALID/WVALID/ARVALID SHALL hold, with address/data stable, until their handshake (AXI rule: no dependence of VALID on READY).
REQ-019 In WRESP, BREADY = 1; on BVALID, capture rsp_err = (BRESP != 2'b00) and go to RESP.
REQ-020 IDLE -> RADDR on an accepted read; ARVALID asserts with ARADDR = cmd_addr; on ARREADY go to RDATA.
REQ-021 In RDATA, RREADY = 1; on RVALID, capture rsp_rdata = RDATA[DW-1:0] and rsp_err = (RRESP != 2'b00), then go to RESP.
REQ-022 In RESP, rsp_valid = 1 with rsp_write/rsp_rdata/rsp_err stable; on rsp_ready go to IDLE; rsp_rdata SHALL be 0 for writes.
REQ-023 Minimum latency, command accept to rsp_valid, SHALL be 3 cycles when the slave responds with zero wait.
REQ-024 A wait counter SHALL clear on each state entry and increment each cycle spent in WADDR/WRESP/RADDR/RDATA; reaching TIMEOUT (if nonzero) SHALL force RESP with rsp_err = 1, deassert all VALID/READY outputs, and leave rsp_rdata = 0.
REQ-025 After a timeout, late B/R beats SHALL be ignored: BREADY/RREADY remain 0 until the next transaction of that type.
REQ-026 Commands presented while not IDLE SHALL be held off (cmd_ready = 0) and not lost.

Reset
REQ-027 On M_AXI_ARESET = 1 at a clock edge: state = IDLE; all M_AXI VALID/READY outputs 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; addresses/WDATA = 0; wait counter = 0.
REQ-028 Reset mid-transaction SHALL abandon it without producing a response; cmd_ready = 1 in the first cycle after reset release.

Verification
REQ-029 Write 0x0008 <- 0x1234, slave ready immediately with BRESP = 0 -> AW/W in the same cycle, rsp_valid 3 cycles after accept, rsp_err = 0.
REQ-030 Write with WREADY 4 cycles before AWREADY -> WVALID drops first, AWVALID held with stable address, single response, rsp_err = 0.
REQ-031 Read 0x0010, slave returns RDATA = 0xABCD5678 with RRESP = 0 -> rsp_rdata = 0x5678, rsp_write = 0.
REQ-032 Read with RRESP = 2'b10 -> rsp_err = 1; rsp_ready held low 5 cycles -> rsp_valid and its data stable throughout.
REQ-033 TIMEOUT = 8, slave never asserts AWREADY -> RESP with rsp_err = 1 after 8 cycles in WADDR, AWVALID = 0 afterwards.
REQ-034 Reset asserted in RDATA -> all outputs at reset values the next cycle, no rsp_valid, next read completes normally.
